// File: rtl/keypad_code_checker.sv
// Keypad code checker: collects BCD digits, compares a full entry against the
// stored access code, and handles failed-attempt lockout, inter-digit timeout
// and guarded code reprogramming.
module keypad_code_checker #(
    parameter int unsigned          CODE_LEN       = 4,
    parameter int unsigned          TIMEOUT_CYCLES = 1000,
    parameter int unsigned          MAX_FAILS      = 3,
    parameter int unsigned          LOCKOUT_CYCLES = 5000,
    parameter logic [4*CODE_LEN-1:0] DEFAULT_CODE  = 16'h1234
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             key_valid,
    input  logic [3:0]                       key_digit,
    input  logic                             key_clear,
    input  logic                             prog_req,
    output logic                             door_status_correct,
    output logic                             door_status_incorrect,
    output logic                             prog_done,
    output logic                             locked_out,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_count
);

    localparam int unsigned CODE_W  = 4 * CODE_LEN;
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ?
                                      TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_PROG    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   entry_q, entry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                win_q, win_d;
    logic                correct_q, correct_d;
    logic                incorrect_q, incorrect_d;
    logic                prog_done_q, prog_done_d;
    logic                locked_q, locked_d;

    logic                key_accept_c;
    logic                last_digit_c;
    logic                timer_expire_c;
    logic [TMR_W-1:0]    timer_dec_c;
    logic [CODE_W-1:0]   full_c;

    // Decode helpers shared by the entry, programming and lockout paths.
    assign key_accept_c   = key_valid && (key_digit <= 4'd9);
    assign last_digit_c   = (cnt_q == CNT_W'(CODE_LEN - 1));
    assign timer_expire_c = (timer_q == TMR_W'(1));
    assign timer_dec_c    = (timer_q == '0) ? '0 : (timer_q - TMR_W'(1));
    assign full_c         = {entry_q[CODE_W-5:0], key_digit};

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        entry_d     = entry_q;
        cnt_d       = cnt_q;
        fail_d      = fail_q;
        timer_d     = timer_q;
        win_d       = win_q;
        correct_d   = 1'b0;
        incorrect_d = 1'b0;
        prog_done_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_ENTRY: begin
                if (key_clear) begin
                    // Clear beats a coincident digit; it also closes the window.
                    state_d = ST_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                    win_d   = 1'b0;
                    timer_d = '0;
                end else if ((state_q == ST_IDLE) && prog_req && win_q) begin
                    state_d = ST_PROG;
                    entry_d = '0;
                    cnt_d   = '0;
                    win_d   = 1'b0;
                    timer_d = TMR_W'(TIMEOUT_CYCLES);
                end else if (key_accept_c) begin
                    win_d = 1'b0;
                    if (last_digit_c) begin
                        state_d = ST_IDLE;
                        entry_d = '0;
                        cnt_d   = '0;
                        if (full_c == code_q) begin
                            correct_d = 1'b1;
                            fail_d    = '0;
                            win_d     = 1'b1;
                            timer_d   = TMR_W'(TIMEOUT_CYCLES);
                        end else begin
                            incorrect_d = 1'b1;
                            if (fail_q >= FAIL_W'(MAX_FAILS - 1)) begin
                                state_d = ST_LOCKOUT;
                                fail_d  = '0;
                                timer_d = TMR_W'(LOCKOUT_CYCLES);
                            end else begin
                                fail_d  = fail_q + FAIL_W'(1);
                                timer_d = '0;
                            end
                        end
                    end else begin
                        state_d = ST_ENTRY;
                        entry_d = full_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        timer_d = TMR_W'(TIMEOUT_CYCLES);
                    end
                end else if (state_q == ST_ENTRY) begin
                    if (timer_expire_c) begin
                        state_d = ST_IDLE;
                        entry_d = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_dec_c;
                    end
                end else if (win_q) begin
                    // Unlock window ages out after an idle timeout.
                    if (timer_expire_c) begin
                        win_d = 1'b0;
                    end
                    timer_d = timer_dec_c;
                end
            end

            ST_PROG: begin
                if (key_clear) begin
                    state_d = ST_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (key_accept_c) begin
                    if (last_digit_c) begin
                        state_d     = ST_IDLE;
                        code_d      = full_c;
                        prog_done_d = 1'b1;
                        entry_d     = '0;
                        cnt_d       = '0;
                        timer_d     = '0;
                    end else begin
                        entry_d = full_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        timer_d = TMR_W'(TIMEOUT_CYCLES);
                    end
                end else if (timer_expire_c) begin
                    state_d = ST_IDLE;
                    entry_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_dec_c;
                end
            end

            ST_LOCKOUT: begin
                if (timer_expire_c) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_dec_c;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        locked_d = (state_d == ST_LOCKOUT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            code_q      <= DEFAULT_CODE;
            entry_q     <= '0;
            cnt_q       <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            win_q       <= 1'b0;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
            prog_done_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            fail_q      <= fail_d;
            timer_q     <= timer_d;
            win_q       <= win_d;
            correct_q   <= correct_d;
            incorrect_q <= incorrect_d;
            prog_done_q <= prog_done_d;
            locked_q    <= locked_d;
        end
    end

    assign door_status_correct   = correct_q;
    assign door_status_incorrect = incorrect_q;
    assign prog_done             = prog_done_q;
    assign locked_out            = locked_q;
    assign digit_count           = cnt_q;

endmodule

// File: tb/tb_keypad_code_checker.sv
// Directed bench for keypad_code_checker.
module tb_keypad_code_checker;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       key_clear;
    logic       prog_req;
    logic       door_status_correct;
    logic       door_status_incorrect;
    logic       prog_done;
    logic       locked_out;
    logic [2:0] digit_count;

    int total = 0;
    int bad   = 0;

    int n_cor  = 0;
    int n_inc  = 0;
    int n_lock = 0;
    logic prev_cor = 1'b0;
    logic prev_inc = 1'b0;
    logic both_seen = 1'b0;
    logic dbl_seen  = 1'b0;

    keypad_code_checker dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .key_valid             (key_valid),
        .key_digit             (key_digit),
        .key_clear             (key_clear),
        .prog_req              (prog_req),
        .door_status_correct   (door_status_correct),
        .door_status_incorrect (door_status_incorrect),
        .prog_done             (prog_done),
        .locked_out            (locked_out),
        .digit_count           (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and lockout monitor sampled on the inactive edge.
    always @(negedge clk) begin
        if (door_status_correct)   n_cor++;
        if (door_status_incorrect) n_inc++;
        if (locked_out)            n_lock++;
        if (door_status_correct && door_status_incorrect) both_seen = 1'b1;
        if ((door_status_correct && prev_cor) || (door_status_incorrect && prev_inc))
            dbl_seen = 1'b1;
        prev_cor = door_status_correct;
        prev_inc = door_status_incorrect;
    end

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    // Four digits, MS nibble first, 3 idle cycles between strobes; returns on
    // the negedge right after the final digit was sampled.
    task automatic enter4(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            press(c[15-4*i -: 4]);
            if (i < 3) repeat (3) @(negedge clk);
        end
    endtask

    task automatic pulse_prog_req();
        @(negedge clk);
        prog_req = 1'b1;
        @(negedge clk);
        prog_req = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        key_clear = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;
        prog_req  = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({door_status_correct, door_status_incorrect, prog_done, locked_out} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=0000",
                     {door_status_correct, door_status_incorrect, prog_done, locked_out});
        end
        total++;
        if (digit_count !== 3'd0) begin
            bad++;
            $display("FAIL reset_count got=%0d want=0", digit_count);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({door_status_correct, door_status_incorrect, prog_done, locked_out, digit_count} !== 7'd0) begin
            bad++;
            $display("FAIL post_reset_idle got=%b want=0", {door_status_correct,
                     door_status_incorrect, prog_done, locked_out, digit_count});
        end
    endtask

    task automatic test_correct();
        press(4'd1);
        repeat (3) @(negedge clk);
        press(4'd2);
        total++;
        if (digit_count !== 3'd2) begin
            bad++;
            $display("FAIL count_after_2 got=%0d want=2", digit_count);
        end
        repeat (3) @(negedge clk);
        press(4'd3);
        repeat (3) @(negedge clk);
        press(4'd4);
        total++;
        if ({door_status_correct, door_status_incorrect} !== 2'b10) begin
            bad++;
            $display("FAIL correct_pulse got=%b want=10", {door_status_correct, door_status_incorrect});
        end
        total++;
        if (digit_count !== 3'd0) begin
            bad++;
            $display("FAIL count_after_code got=%0d want=0", digit_count);
        end
        @(negedge clk);
        total++;
        if (door_status_correct !== 1'b0) begin
            bad++;
            $display("FAIL correct_one_cycle got=%b want=0", door_status_correct);
        end
    endtask

    // Two wrongs, a right, then two wrongs must not lock out.
    task automatic test_fail_clear();
        repeat (3) @(negedge clk);
        enter4(16'h1235);
        repeat (3) @(negedge clk);
        enter4(16'h1235);
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        repeat (3) @(negedge clk);
        enter4(16'h1235);
        repeat (3) @(negedge clk);
        enter4(16'h1235);
        total++;
        if ({door_status_incorrect, locked_out} !== 2'b10) begin
            bad++;
            $display("FAIL fail_count_cleared got=%b want=10", {door_status_incorrect, locked_out});
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        total++;
        if (door_status_correct !== 1'b1) begin
            bad++;
            $display("FAIL fail_clear_correct got=%b want=1", door_status_correct);
        end
    endtask

    task automatic test_lockout();
        int snap;
        int k;
        n_lock = 0;
        for (int r = 0; r < 3; r++) begin
            repeat (3) @(negedge clk);
            enter4(16'h1235);
            total++;
            if ({door_status_correct, door_status_incorrect} !== 2'b01) begin
                bad++;
                $display("FAIL wrong_code_%0d got=%b want=01", r,
                         {door_status_correct, door_status_incorrect});
            end
        end
        total++;
        if (locked_out !== 1'b1) begin
            bad++;
            $display("FAIL lockout_entry got=%b want=1", locked_out);
        end
        @(negedge clk);
        #1;
        snap = n_cor + n_inc;
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ((n_cor + n_inc) !== snap) begin
            bad++;
            $display("FAIL lockout_keys_ignored got=%0d want=%0d", n_cor + n_inc, snap);
        end
        total++;
        if (digit_count !== 3'd0) begin
            bad++;
            $display("FAIL lockout_count got=%0d want=0", digit_count);
        end
        k = 0;
        while (locked_out && k < 6000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (locked_out !== 1'b0) begin
            bad++;
            $display("FAIL lockout_release got=%b want=0", locked_out);
        end
        #1;
        total++;
        if (n_lock !== 5000) begin
            bad++;
            $display("FAIL lockout_duration got=%0d want=5000", n_lock);
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        total++;
        if (door_status_correct !== 1'b1) begin
            bad++;
            $display("FAIL after_lockout_correct got=%b want=1", door_status_correct);
        end
    endtask

    task automatic test_timeout();
        int snap;
        repeat (3) @(negedge clk);
        #1;
        snap = n_cor + n_inc;
        press(4'd1);
        repeat (3) @(negedge clk);
        press(4'd2);
        repeat (999) @(negedge clk);
        total++;
        if (digit_count !== 3'd2) begin
            bad++;
            $display("FAIL timeout_early got=%0d want=2", digit_count);
        end
        @(negedge clk);
        total++;
        if (digit_count !== 3'd0) begin
            bad++;
            $display("FAIL timeout_discard got=%0d want=0", digit_count);
        end
        #1;
        total++;
        if ((n_cor + n_inc) !== snap) begin
            bad++;
            $display("FAIL timeout_no_pulse got=%0d want=%0d", n_cor + n_inc, snap);
        end
        repeat (3) @(negedge clk);
        enter4(16'h3412);
        total++;
        if ({door_status_correct, door_status_incorrect} !== 2'b01) begin
            bad++;
            $display("FAIL timeout_then_3412 got=%b want=01", {door_status_correct, door_status_incorrect});
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
    endtask

    task automatic test_filter_clear();
        repeat (3) @(negedge clk);
        press(4'd1);
        press(4'hB);
        total++;
        if (digit_count !== 3'd1) begin
            bad++;
            $display("FAIL bad_digit_ignored got=%0d want=1", digit_count);
        end
        press(4'd2);
        press(4'd3);
        @(negedge clk);
        key_clear = 1'b1;
        key_valid = 1'b1;
        key_digit = 4'd4;
        @(negedge clk);
        key_clear = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        total++;
        if ({digit_count, door_status_correct, door_status_incorrect} !== 5'd0) begin
            bad++;
            $display("FAIL clear_wins got=%b want=00000",
                     {digit_count, door_status_correct, door_status_incorrect});
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        total++;
        if (door_status_correct !== 1'b1) begin
            bad++;
            $display("FAIL after_clear_correct got=%b want=1", door_status_correct);
        end
    endtask

    task automatic test_prog();
        pulse_clear();
        pulse_prog_req();
        repeat (3) @(negedge clk);
        enter4(16'h9876);
        total++;
        if ({prog_done, door_status_incorrect} !== 2'b01) begin
            bad++;
            $display("FAIL prog_req_ignored got=%b want=01", {prog_done, door_status_incorrect});
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        pulse_prog_req();
        repeat (3) @(negedge clk);
        enter4(16'h9876);
        total++;
        if ({prog_done, door_status_correct, door_status_incorrect} !== 3'b100) begin
            bad++;
            $display("FAIL prog_done_pulse got=%b want=100",
                     {prog_done, door_status_correct, door_status_incorrect});
        end
        @(negedge clk);
        total++;
        if (prog_done !== 1'b0) begin
            bad++;
            $display("FAIL prog_done_one_cycle got=%b want=0", prog_done);
        end
        repeat (3) @(negedge clk);
        enter4(16'h9876);
        total++;
        if (door_status_correct !== 1'b1) begin
            bad++;
            $display("FAIL new_code_correct got=%b want=1", door_status_correct);
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        total++;
        if (door_status_incorrect !== 1'b1) begin
            bad++;
            $display("FAIL old_code_rejected got=%b want=1", door_status_incorrect);
        end
        repeat (3) @(negedge clk);
        enter4(16'h9876);
    endtask

    task automatic test_reset_mid();
        pulse_prog_req();
        press(4'd5);
        press(4'd5);
        total++;
        if (digit_count !== 3'd2) begin
            bad++;
            $display("FAIL mid_prog_count got=%0d want=2", digit_count);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({door_status_correct, door_status_incorrect, prog_done, locked_out, digit_count} !== 7'd0) begin
            bad++;
            $display("FAIL async_reset_prog got=%b want=0", {door_status_correct,
                     door_status_incorrect, prog_done, locked_out, digit_count});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        enter4(16'h1234);
        total++;
        if (door_status_correct !== 1'b1) begin
            bad++;
            $display("FAIL code_reverted got=%b want=1", door_status_correct);
        end
        for (int r = 0; r < 3; r++) begin
            repeat (3) @(negedge clk);
            enter4(16'h1235);
        end
        repeat (100) @(negedge clk);
        total++;
        if (locked_out !== 1'b1) begin
            bad++;
            $display("FAIL mid_lockout got=%b want=1", locked_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({locked_out, door_status_incorrect} !== 2'b00) begin
            bad++;
            $display("FAIL async_reset_lockout got=%b want=00", {locked_out, door_status_incorrect});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        enter4(16'h1235);
        repeat (3) @(negedge clk);
        enter4(16'h1235);
        total++;
        if ({door_status_incorrect, locked_out} !== 2'b10) begin
            bad++;
            $display("FAIL reset_clears_fails got=%b want=10", {door_status_incorrect, locked_out});
        end
        repeat (3) @(negedge clk);
        enter4(16'h1234);
        total++;
        if (door_status_correct !== 1'b1) begin
            bad++;
            $display("FAIL final_correct got=%b want=1", door_status_correct);
        end
    endtask

    task automatic test_pulse_rules();
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({both_seen, dbl_seen} !== 2'b00) begin
            bad++;
            $display("FAIL pulse_rules got=%b want=00", {both_seen, dbl_seen});
        end
    endtask

    initial begin
        test_reset();
        test_correct();
        test_fail_clear();
        test_lockout();
        test_timeout();
        test_filter_clear();
        test_prog();
        test_reset_mid();
        test_pulse_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_code_checker.md
Name: keypad_code_checker

Overview:
- Keypad-side front end of the dorm lock. Collects decimal digits from the keypad scanner and compares the completed entry against a stored access code.
- Emits single-cycle door_status_correct / door_status_incorrect pulses. These are the result inputs consumed by the lock state machine.
- Also provides failed-attempt lockout, an inter-digit timeout, and a guarded code-reprogramming sequence.

Parameters:
- CODE_LEN, 4: digits per code.
- TIMEOUT_CYCLES, 1000: idle cycles allowed between digits before a partial entry is discarded.
- MAX_FAILS, 3: consecutive incorrect codes that trigger lockout.
- LOCKOUT_CYCLES, 5000: lockout duration in clk cycles.
- DEFAULT_CODE, 16'h1234: code loaded at reset, BCD, first digit in the MS nibble; width 4*CODE_LEN.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  single-cycle strobe; key_digit is valid this cycle.
- key_digit  in  4  keypad digit, 0-9 meaningful.
- key_clear  in  1  single-cycle strobe; discard the partial entry.
- prog_req  in  1  single-cycle strobe; request code reprogramming.
- door_status_correct  out  1  one-cycle pulse: entered code matched.
- door_status_incorrect  out  1  one-cycle pulse: entered code mismatched.
- prog_done  out  1  one-cycle pulse: new code stored.
- locked_out  out  1  high while in lockout.
- digit_count  out  $clog2(CODE_LEN+1)  digits captured in the current entry.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE; stored code=DEFAULT_CODE.
  - Entry buffer, digit_count, fail counter, timer and unlock_window all cleared.
  - All outputs 0.
- States:
  - IDLE: no digits held.
  - ENTRY: partial code held.
  - PROG: capturing a new code.
  - LOCKOUT.
- Key filtering: key_valid with key_digit > 9 is ignored entirely. It does not advance the count and does not reset the timer.
- IDLE/ENTRY digit capture:
  - Each accepted digit shifts into the entry buffer, increments digit_count, reloads the timer, and moves IDLE->ENTRY.
  - On the CODE_LEN-th digit, the full entry (buffer plus this digit) is compared to the stored code.
  - Exactly one of correct/incorrect pulses high in the cycle after the edge that sampled the final key_valid (latency 1).
  - digit_count then returns to 0 and state returns to IDLE.
- Correct result: clears the fail counter and sets unlock_window.
- Incorrect result:
  - Increments the fail counter.
  - If the counter reaches MAX_FAILS, go to LOCKOUT instead of IDLE: counter cleared, timer loaded with LOCKOUT_CYCLES.
- Pulse rules: door_status_correct and door_status_incorrect are never high together, and each is never high for 2 consecutive cycles.
- Timeout:
  - In ENTRY, TIMEOUT_CYCLES cycles with no accepted digit discards the entry and returns to IDLE.
  - No pulse is produced and the fail counter is unchanged.
- key_clear:
  - In ENTRY or PROG, discards the partial entry and returns to IDLE. No pulse; fail count unchanged.
  - key_clear and key_valid in the same cycle: clear wins and the digit is dropped.
- unlock_window:
  - Set by a correct result.
  - Cleared by the next accepted digit, key_clear, TIMEOUT_CYCLES cycles of inactivity in IDLE, or entry to PROG.
  - prog_req is honoured only in IDLE with unlock_window=1; otherwise it is ignored.
- PROG:
  - The next CODE_LEN accepted digits load a shadow register.
  - After the last digit, the stored code is replaced and prog_done pulses one cycle (latency 1). Return to IDLE.
  - Timeout or key_clear in PROG aborts; the old code is kept and there is no prog_done.
  - PROG never produces correct/incorrect pulses.
- LOCKOUT:
  - locked_out=1; key_valid, key_clear and prog_req are all ignored.
  - After LOCKOUT_CYCLES cycles, locked_out drops and state returns to IDLE with digit_count=0.
- Reset mid-operation: reset aborts anything in progress, including PROG and LOCKOUT. The stored code reverts to DEFAULT_CODE.
- Timer: a single down-counter shared by the timeout and lockout functions, sized for max(TIMEOUT_CYCLES, LOCKOUT_CYCLES).

Test Plan:
- Enter keys 1,2,3,4 (one strobe each, 3-cycle gaps) -> door_status_correct high for exactly 1 cycle, one cycle after the key-4 edge; fail count 0; digit_count returns 0.
- Enter 1,2,3,5 three times -> three door_status_incorrect pulses. After the third: locked_out=1 for 5000 cycles, keys 1,2,3,4 during lockout produce no pulse, and 1,2,3,4 afterwards yields correct.
- Enter 1,2, then wait 1000 idle cycles, then 3,4,1,2 -> incorrect pulse, not correct (partial entry discarded); no pulse at the timeout.
- Key 0xB inserted mid-entry, and key_clear coincident with key_valid -> 0xB ignored; clear discards the entry and drops the coincident digit.
- Correct 1,2,3,4, then prog_req, then 9,8,7,6 -> prog_done pulse. 9,8,7,6 now yields correct and 1,2,3,4 yields incorrect. prog_req without a preceding correct entry is ignored.
- Assert reset_n low asynchronously mid-PROG and mid-LOCKOUT -> all outputs 0 immediately, the code reverts to 1,2,3,4, and the fail count is 0.
